// File: rtl/imem_loader_if.sv
// Byte-stream input and memory write-port bundle for the instruction memory loader.
interface imem_loader_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [7:0]            byte_data;
  logic                  byte_valid;
  logic                  byte_ready;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] WD;
  logic                  WE;

  // Loader side: consumes the byte stream, drives the memory write port.
  modport master (
    input  byte_data, byte_valid,
    output byte_ready, A, WD, WE
  );

  // Environment side: produces bytes, observes memory writes.
  modport slave (
    output byte_data, byte_valid,
    input  byte_ready, A, WD, WE
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: packs a little-endian byte stream into words and
// writes them to consecutive addresses, holding the core disabled meanwhile.
module imem_loader #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEM_CAPACITY = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] base_addr,
  input  logic [DATA_WIDTH-1:0] word_count,
  imem_loader_if.master         bus,
  output logic                  cpu_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned SUM_W = DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  cpu_en_q, cpu_en_d;

  logic                  byte_acc;
  logic                  range_err;
  logic [SUM_W-1:0]      end_addr;

  assign byte_acc  = bus.byte_valid && byte_ready_q;
  // One extra bit so base + count cannot wrap past the capacity check.
  assign end_addr  = SUM_W'(base_addr) + SUM_W'(word_count);
  assign range_err = end_addr > SUM_W'(MEM_CAPACITY);

  // State and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      idx_q        <= '0;
      asm_q        <= '0;
      byte_ready_q <= 1'b0;
      we_q         <= 1'b0;
      a_q          <= '0;
      wd_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cpu_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      idx_q        <= idx_d;
      asm_q        <= asm_d;
      byte_ready_q <= byte_ready_d;
      we_q         <= we_d;
      a_q          <= a_d;
      wd_q         <= wd_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      cpu_en_q     <= cpu_en_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they line up
  // with the state they belong to once registered.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    asm_d    = asm_q;
    error_d  = error_q;
    cpu_en_d = cpu_en_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count == '0) begin
            error_d = 1'b0;
            state_d = DONE;
          end else if (range_err) begin
            error_d = 1'b1;
          end else begin
            addr_d   = base_addr;
            rem_d    = word_count;
            idx_d    = '0;
            asm_d    = '0;
            error_d  = 1'b0;
            cpu_en_d = 1'b0;
            state_d  = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (byte_acc) begin
          asm_d[{idx_q, 3'b000} +: 8] = bus.byte_data;
          if (idx_q == IDX_W'(BYTES - 1)) begin
            idx_d   = '0;
            state_d = WRITE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      WRITE: begin
        addr_d  = addr_q + DATA_WIDTH'(1);
        rem_d   = rem_q - DATA_WIDTH'(1);
        idx_d   = '0;
        state_d = (rem_q == DATA_WIDTH'(1)) ? DONE : COLLECT;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    byte_ready_d = (state_d == COLLECT);
    we_d         = (state_d == WRITE);
    a_d          = we_d ? addr_q : '0;
    wd_d         = we_d ? asm_d : '0;
    busy_d       = (state_d == COLLECT) || (state_d == WRITE);
    done_d       = (state_d == DONE);
    if (state_d == DONE) begin
      cpu_en_d = 1'b1;
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.WE         = we_q;
  assign bus.A          = a_q;
  assign bus.WD         = wd_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign cpu_en         = cpu_en_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus
// and checked by an independent monitor on every WE pulse.
module tb_imem_loader;

  localparam int unsigned DW  = 32;
  localparam int unsigned CAP = 10;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] wd;
  } wr_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] base_addr = '0;
  logic [DW-1:0] word_count = '0;
  logic          cpu_en, busy, done, error;

  imem_loader_if #(.DATA_WIDTH(DW)) bus ();

  imem_loader #(.DATA_WIDTH(DW), .MEM_CAPACITY(CAP)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .bus        (bus),
    .cpu_en     (cpu_en),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  wr_t           exp_q[$];
  wr_t           exp_e;
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            hs_cyc = -10;
  int            we_count = 0;
  logic [DW-1:0] last_a = '0;

  logic [7:0]    stream2 [8] = '{8'h03, 8'hA3, 8'hC4, 8'hFF, 8'h23, 8'hA4, 8'h64, 8'h00};
  logic [7:0]    big [40];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.WE) begin
      we_count++;
      last_a = bus.A;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write A=%h WD=%h required=none", bus.A, bus.WD);
      end else begin
        exp_e = exp_q.pop_front();
        if (bus.A !== exp_e.a || bus.WD !== exp_e.wd) begin
          failures++;
          $display("FAIL write_data A=%h WD=%h required A=%h WD=%h", bus.A, bus.WD, exp_e.a, exp_e.wd);
        end
      end
      checks++;
      if (cyc != hs_cyc + 1) begin
        failures++;
        $display("FAIL write_latency actual=%0d required=1", cyc - hs_cyc);
      end
      checks++;
      if (bus.A >= CAP) begin
        failures++;
        $display("FAIL write_range A=%h required<%0d", bus.A, CAP);
      end
    end else begin
      checks++;
      if (bus.A !== '0 || bus.WD !== '0) begin
        failures++;
        $display("FAIL idle_bus A=%h WD=%h required 0", bus.A, bus.WD);
      end
    end
    if (bus.byte_valid && bus.byte_ready) hs_cyc = cyc;
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] wd);
    wr_t e;
    e.a  = a;
    e.wd = wd;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [DW-1:0] b, input logic [DW-1:0] c);
    @(posedge clk);
    #1 start = 1'b1; base_addr = b; word_count = c;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse_start);
    int n;
    repeat (gap) @(posedge clk);
    #1 bus.byte_data = b; bus.byte_valid = 1'b1;
    if (pulse_start) begin
      start = 1'b1; base_addr = 5; word_count = 1;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.byte_ready && n < 50);
    chk("byte_ready_timeout", DW'(n < 50), DW'(1));
    chk("busy_during_load", DW'(busy), DW'(1));
    @(posedge clk);
    #1 bus.byte_valid = 1'b0; start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, DW'(done), DW'(1));
    chk({name, "_busy_in_done"}, DW'(busy), DW'(0));
    chk({name, "_cpu_en"}, DW'(cpu_en), DW'(1));
    @(negedge clk);
    chk({name, "_done_pulse"}, DW'(done), DW'(0));
    chk({name, "_cpu_en_idle"}, DW'(cpu_en), DW'(1));
  endtask

  initial begin
    int wc;
    logic [DW-1:0] w;

    bus.byte_data  = 8'h00;
    bus.byte_valid = 1'b0;

    // 1: reset values; byte_valid ignored during and after reset
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h5A;
    repeat (2) @(negedge clk);
    chk("rst_byte_ready", DW'(bus.byte_ready), DW'(0));
    chk("rst_we", DW'(bus.WE), DW'(0));
    chk("rst_a", bus.A, DW'(0));
    chk("rst_wd", bus.WD, DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_done", DW'(done), DW'(0));
    chk("rst_error", DW'(error), DW'(0));
    chk("rst_cpu_en", DW'(cpu_en), DW'(0));
    @(posedge clk);
    #1 rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_byte_ready", DW'(bus.byte_ready), DW'(0));
      chk("idle_busy", DW'(busy), DW'(0));
    end
    bus.byte_valid = 1'b0;

    // 2: two words, back-to-back bytes
    wc = we_count;
    push(0, 32'hFFC4A303);
    push(1, 32'h0064A423);
    do_start(0, 2);
    chk("s2_busy", DW'(busy), DW'(1));
    chk("s2_cpu_en_low", DW'(cpu_en), DW'(0));
    for (int i = 0; i < 8; i++) send_byte(stream2[i], 0, 1'b0);
    wait_done("s2");
    chk("s2_we_count", DW'(we_count - wc), DW'(2));
    chk("s2_queue_empty", DW'(exp_q.size()), DW'(0));

    // 3: same load with random gaps and a stray start mid-load
    wc = we_count;
    push(0, 32'hFFC4A303);
    push(1, 32'h0064A423);
    do_start(0, 2);
    for (int i = 0; i < 8; i++) send_byte(stream2[i], int'($urandom_range(0, 3)), i == 2);
    wait_done("s3");
    chk("s3_we_count", DW'(we_count - wc), DW'(2));
    chk("s3_queue_empty", DW'(exp_q.size()), DW'(0));

    // 4: boundaries
    wc = we_count;
    do_start(0, 0);
    wait_done("s4_cnt0");
    chk("s4_cnt0_no_we", DW'(we_count - wc), DW'(0));
    do_start(8, 3);
    @(negedge clk);
    chk("s4_range_error", DW'(error), DW'(1));
    chk("s4_range_cpu_en", DW'(cpu_en), DW'(1));
    for (int i = 0; i < 3; i++) begin
      chk("s4_range_busy", DW'(busy), DW'(0));
      @(negedge clk);
    end
    chk("s4_range_error_sticky", DW'(error), DW'(1));
    chk("s4_range_no_we", DW'(we_count - wc), DW'(0));
    push(8, 32'hFFC4A303);
    push(9, 32'h0064A423);
    do_start(8, 2);
    chk("s4_error_cleared", DW'(error), DW'(0));
    chk("s4_edge_busy", DW'(busy), DW'(1));
    for (int i = 0; i < 8; i++) send_byte(stream2[i], 0, 1'b0);
    wait_done("s4_edge");
    chk("s4_edge_we_count", DW'(we_count - wc), DW'(2));
    chk("s4_edge_last_a", last_a, DW'(9));

    // 5: full 10-word load
    wc = we_count;
    for (int j = 0; j < 40; j++) big[j] = 8'(j * 17 + 5);
    for (int i = 0; i < 10; i++) begin
      w = {big[4*i+3], big[4*i+2], big[4*i+1], big[4*i]};
      push(DW'(i), w);
    end
    do_start(0, 10);
    for (int j = 0; j < 40; j++) send_byte(big[j], 0, 1'b0);
    wait_done("s5");
    chk("s5_we_count", DW'(we_count - wc), DW'(10));
    chk("s5_last_a", last_a, DW'(9));
    chk("s5_queue_empty", DW'(exp_q.size()), DW'(0));

    // 6: reset mid-load discards the partial word
    wc = we_count;
    push(0, 32'h44332211);
    do_start(0, 3);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    send_byte(8'h33, 0, 1'b0);
    send_byte(8'h44, 0, 1'b0);
    send_byte(8'hAA, 0, 1'b0);
    send_byte(8'hBB, 0, 1'b0);
    rstn = 1'b0;
    #1;
    chk("s6_rst_busy", DW'(busy), DW'(0));
    chk("s6_rst_cpu_en", DW'(cpu_en), DW'(0));
    chk("s6_rst_byte_ready", DW'(bus.byte_ready), DW'(0));
    chk("s6_rst_we", DW'(bus.WE), DW'(0));
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    chk("s6_we_count_after_rst", DW'(we_count - wc), DW'(1));
    push(3, 32'hDDCCBBAA);
    do_start(3, 1);
    send_byte(8'hAA, 0, 1'b0);
    send_byte(8'hBB, 0, 1'b0);
    send_byte(8'hCC, 0, 1'b0);
    send_byte(8'hDD, 0, 1'b0);
    wait_done("s6_reload");
    chk("s6_we_count", DW'(we_count - wc), DW'(2));
    chk("s6_queue_empty", DW'(exp_q.size()), DW'(0));

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side master for the instruction memory's write port (A, WD, WE).
- Accepts a little-endian byte stream over a valid/ready handshake and assembles bytes into DATA_WIDTH-bit words.
- Writes each completed word to consecutive word addresses, starting at a programmed base address.
- Holds the core disabled (cpu_en low) while loading and releases it when the load completes.

Parameters:
DATA_WIDTH, 32, word width; must be a multiple of 8; BYTES = DATA_WIDTH/8.
MEM_CAPACITY, 10, number of words in the target memory; used for range checking.

Ports:
clk  input  1  system clock, rising edge.
rstn  input  1  asynchronous active-low reset.
start  input  1  single-cycle request to begin a load; sampled in IDLE only.
base_addr  input  DATA_WIDTH  first word address; latched on an accepted start.
word_count  input  DATA_WIDTH  number of words to load; latched on an accepted start.
byte_data  input  8  stream byte.
byte_valid  input  1  byte_data is valid.
byte_ready  output  1  loader can accept a byte.
A  output  DATA_WIDTH  memory word address.
WD  output  DATA_WIDTH  memory write data.
WE  output  1  memory write enable; single-cycle pulse per word.
cpu_en  output  1  core enable; low while loading.
busy  output  1  load in progress.
done  output  1  single-cycle pulse when a load completes.
error  output  1  range error; sticky until the next accepted start.

Behaviour:
- Interface: one clock (clk); reset rstn is asynchronous, active-low. All outputs are registered.
- Reset values: state IDLE; byte_ready, WE, busy, done, error, cpu_en = 0; A, WD = 0; byte index, word counter and assembly register cleared.
- States: IDLE, COLLECT, WRITE, DONE.

IDLE
- byte_ready = 0.
- start with word_count == 0: go to DONE; no write occurs.
- start with base_addr + word_count > MEM_CAPACITY, computed one bit wider than DATA_WIDTH so it cannot overflow:
  - error = 1 on the next cycle; remain in IDLE; no write occurs.
- Otherwise: latch base_addr and word_count; clear error; busy = 1 and cpu_en = 0 on the next cycle; go to COLLECT.
- start is ignored in every state other than IDLE.

COLLECT
- byte_ready = 1.
- A byte is accepted on a cycle where byte_valid && byte_ready.
- Byte k of a word (k = 0..BYTES-1) is placed in bits [8k+7 : 8k]; the first byte is the LSB.
- On accepting byte BYTES-1, move to WRITE on the next cycle.
- Bytes offered while byte_ready = 0 are not consumed.

WRITE (exactly one cycle)
- WE = 1; A = current address; WD = assembled word; byte_ready = 0.
- The WE cycle is the cycle immediately after the last byte handshake (latency 1).
- Then: address + 1, remaining - 1, byte index cleared.
- If remaining == 0, go to DONE; otherwise return to COLLECT.
- Minimum throughput: BYTES + 1 cycles per word.

DONE (exactly one cycle)
- done = 1 and busy = 0 in this cycle; cpu_en = 1 from this cycle onward.
- Return to IDLE.

Other rules
- A and WD are 0 in every cycle where WE = 0.
- Reset asserted mid-load: abort immediately to reset values and discard the partial word. Words already written are not rewritten by the loader.
- cpu_en stays 1 in IDLE after a successful load. An error does not change cpu_en.
- No write ever targets an address ≥ MEM_CAPACITY.

Test Plan:
1. Reset, then hold → all outputs 0, state IDLE, byte_ready 0; byte_valid pulses are ignored.
2. start, base 0, count 2; stream 03 A3 C4 FF 23 A4 64 00, one byte per cycle → WE at A=0, WD=FFC4A303, one cycle after the 4th byte; WE at A=1, WD=0064A423; done pulse; cpu_en 1; exactly 2 WE pulses.
3. Same load as scenario 2 with random 0–3 cycle gaps on byte_valid, plus a start pulse mid-load → identical writes; the extra start is ignored; busy stays 1 until DONE.
4. Boundary checks (no WE in any case):
   - count 0 → done pulse.
   - base 8, count 3 → error 1, busy never asserted.
   - A following valid start clears error.
5. Load 10 words at base 0 → last WE at A=9; all 10 WD values match the stream.
6. rstn low after 2 bytes of the second word → WE never pulses for that word; busy, cpu_en, byte_ready = 0; a new load after reset completes normally.
